// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier datapath: controller state
// encoding and default geometry, so the FSM and the accumulator agree.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_IN_W   = 8;
    localparam int DEF_STEP   = 4;
    localparam int DEF_SC_W   = 2;
    localparam int DEF_NSHIFT = 3;
    localparam int DEF_NTERMS = 4;
    localparam int DEF_OUT_W  = 16;

endpackage

// File: rtl/shift_accumulator_if.sv
// Term/handshake bundle between the multiplier controller (master) and the
// shift accumulator (slave).
interface shift_accumulator_if #(
    parameter int IN_W  = 8,
    parameter int SC_W  = 2,
    parameter int OUT_W = 16
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  inp;
    logic [SC_W-1:0]  shift_cntrl;
    logic [OUT_W-1:0] result;
    logic             done;
    logic             busy;
    logic             overflow;

    modport master (
        output start, in_valid, inp, shift_cntrl,
        input  in_ready, result, done, busy, overflow
    );

    modport slave (
        input  start, in_valid, inp, shift_cntrl,
        output in_ready, result, done, busy, overflow
    );
endinterface

// File: rtl/param_shifter.sv
// Combinational partial-product shifter: zero-extends an IN_W term to OUT_W
// and shifts it left by code*STEP. Codes outside 0..NSHIFT-1 pass the term
// through unshifted, as the legacy fixed shifter did. Bits pushed beyond
// OUT_W are dropped.
module param_shifter #(
    parameter int IN_W   = 8,
    parameter int STEP   = 4,
    parameter int SC_W   = 2,
    parameter int NSHIFT = 3,
    parameter int OUT_W  = 16
) (
    input  logic [IN_W-1:0]  inp_i,
    input  logic [SC_W-1:0]  code_i,
    output logic [OUT_W-1:0] term_o
);

    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] cand [NSHIFT];
    logic [NSHIFT-1:0] hit;

    assign ext = OUT_W'(inp_i);

    // One pre-shifted candidate and one code decoder per legal shift code.
    for (genvar gi = 0; gi < NSHIFT; gi++) begin : g_cand
        localparam logic [SC_W-1:0] CODE = SC_W'(gi);
        assign cand[gi] = ext << (gi * STEP);
        assign hit[gi]  = (code_i == CODE);
    end

    // Select the matching candidate; no match (illegal code) falls back to shift 0.
    always_comb begin
        term_o = cand[0];
        for (int i = 1; i < NSHIFT; i++) begin
            if (hit[i]) begin
                term_o = cand[i];
            end
        end
    end

endmodule

// File: rtl/shift_accumulator.sv
// Shift-and-accumulate stage of the sequential multiplier. Each accepted
// partial product is shifted by a selectable multiple of STEP and added into
// the result register; after NTERMS accepts the block pulses done for one
// cycle with the final product held in result.
module shift_accumulator
    import mult_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int STEP   = DEF_STEP,
    parameter int SC_W   = DEF_SC_W,
    parameter int NSHIFT = DEF_NSHIFT,
    parameter int NTERMS = DEF_NTERMS,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    shift_accumulator_if.slave bus
);

    localparam int CNT_W = $clog2(NTERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NTERMS - 1);

    state_t           state_q;
    logic [OUT_W-1:0] result_q;
    logic             overflow_q;
    logic [CNT_W-1:0] count_q;

    logic [OUT_W-1:0] term_d;
    logic [OUT_W:0]   sum_d;
    logic             accept_d;

    param_shifter #(
        .IN_W   (IN_W),
        .STEP   (STEP),
        .SC_W   (SC_W),
        .NSHIFT (NSHIFT),
        .OUT_W  (OUT_W)
    ) u_shifter (
        .inp_i  (bus.inp),
        .code_i (bus.shift_cntrl),
        .term_o (term_d)
    );

    // A start in the same cycle wins: the presented term is discarded.
    assign accept_d = (state_q == RUN) && bus.in_valid && !bus.start;

    // Extra top bit captures the carry out of the accumulator.
    assign sum_d = {1'b0, result_q} + {1'b0, term_d};

    // Controller FSM, term counter, accumulator and sticky overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            result_q   <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else if (bus.start) begin
            state_q    <= RUN;
            result_q   <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept_d) begin
                        result_q   <= sum_d[OUT_W-1:0];
                        overflow_q <= overflow_q | sum_d[OUT_W];
                        count_q    <= count_q + CNT_W'(1);
                        if (count_q == LAST_CNT) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Status outputs decode straight from the state register, so reset clears them at once.
    assign bus.in_ready = (state_q == RUN);
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_shift_accumulator.sv
// Directed test of shift_accumulator: reset, full 8x8 product, illegal shift
// code, overflow, restart priority and asynchronous reset mid-operation.
module tb_shift_accumulator;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    shift_accumulator_if #(.IN_W(8), .SC_W(2), .OUT_W(16)) bus ();

    shift_accumulator dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start    = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        bus.start    = 1'b0;
        $display("start: result=0x%0h busy=%0b", bus.result, bus.busy);
    endtask

    // Present one term for one cycle; in_valid is left asserted for back-to-back use.
    task automatic term(input logic [7:0] v, input logic [1:0] code);
        bus.in_valid    = 1'b1;
        bus.inp         = v;
        bus.shift_cntrl = code;
        tick();
        $display("term inp=0x%0h code=%0d: result=0x%0h done=%0b ovf=%0b",
                 v, code, bus.result, bus.done, bus.overflow);
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.inp         = '0;
        bus.shift_cntrl = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.start       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.inp         = '0;
        bus.shift_cntrl = '0;
        reset_n         = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.start       = 1'($urandom);
            bus.in_valid    = 1'($urandom);
            bus.inp         = 8'($urandom);
            bus.shift_cntrl = 2'($urandom);
            tick();
        end
        check("rst_result",   32'(bus.result),   32'h0);
        check("rst_done",     32'(bus.done),     32'h0);
        check("rst_busy",     32'(bus.busy),     32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_overflow", 32'(bus.overflow), 32'h0);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.inp      = 8'h55;
        reset_n      = 1'b1;
        tick();
        tick();
        check("idle_busy",     32'(bus.busy),     32'h0);
        check("idle_in_ready", 32'(bus.in_ready), 32'h0);
        check("idle_result",   32'(bus.result),   32'h0);
        idle_inputs();

        // 8x8 product, terms back to back
        do_start();
        check("p_busy",     32'(bus.busy),     32'h1);
        check("p_in_ready", 32'(bus.in_ready), 32'h1);
        term(8'hE1, 2'd0);
        check("p_acc1", 32'(bus.result), 32'h00E1);
        term(8'hE1, 2'd1);
        check("p_acc2", 32'(bus.result), 32'h0EF1);
        term(8'hE1, 2'd1);
        check("p_acc3", 32'(bus.result), 32'h1D01);
        check("p_nodone3", 32'(bus.done), 32'h0);
        term(8'hE1, 2'd2);
        idle_inputs();
        check("p_result",   32'(bus.result),   32'hFE01);
        check("p_done",     32'(bus.done),     32'h1);
        check("p_busy_dn",  32'(bus.busy),     32'h0);
        check("p_rdy_dn",   32'(bus.in_ready), 32'h0);
        check("p_overflow", 32'(bus.overflow), 32'h0);
        tick();
        check("p_done_pulse", 32'(bus.done),   32'h0);
        check("p_idle_busy",  32'(bus.busy),   32'h0);
        check("p_hold",       32'(bus.result), 32'hFE01);
        bus.in_valid = 1'b1;
        bus.inp      = 8'hFF;
        tick();
        idle_inputs();
        check("p_idle_ignore", 32'(bus.result), 32'hFE01);

        // Shift code 3 is out of range and passes the term through
        do_start();
        term(8'h6E, 2'd3);
        term(8'h00, 2'd0);
        term(8'h00, 2'd0);
        term(8'h00, 2'd0);
        idle_inputs();
        check("ill_result", 32'(bus.result), 32'h006E);
        check("ill_done",   32'(bus.done),   32'h1);

        // Carry out of the accumulator sets sticky overflow
        do_start();
        term(8'hFF, 2'd2);
        check("ov_acc1", 32'(bus.overflow), 32'h0);
        term(8'hFF, 2'd2);
        check("ov_acc2", 32'(bus.overflow), 32'h1);
        term(8'hFF, 2'd2);
        term(8'hFF, 2'd2);
        idle_inputs();
        check("ov_result", 32'(bus.result),   32'hFC00);
        check("ov_flag",   32'(bus.overflow), 32'h1);
        check("ov_done",   32'(bus.done),     32'h1);
        tick();
        check("ov_sticky", 32'(bus.overflow), 32'h1);
        do_start();
        check("ov_clear", 32'(bus.overflow), 32'h0);
        check("ov_rclr",  32'(bus.result),   32'h0);

        // Restart: start with a valid term discards it and restarts the count
        term(8'h01, 2'd0);
        term(8'h01, 2'd0);
        check("rs_two", 32'(bus.result), 32'h0002);
        bus.start = 1'b1;
        term(8'h01, 2'd0);
        bus.start = 1'b0;
        check("rs_clear", 32'(bus.result), 32'h0);
        check("rs_busy",  32'(bus.busy),   32'h1);
        for (int i = 1; i <= 3; i++) begin
            term(8'h01, 2'd0);
            check("rs_acc",    32'(bus.result), 32'(i));
            check("rs_nodone", 32'(bus.done),   32'h0);
        end
        term(8'h01, 2'd0);
        idle_inputs();
        check("rs_result", 32'(bus.result), 32'h0004);
        check("rs_done",   32'(bus.done),   32'h1);
        tick();

        // Asynchronous reset between edges mid-RUN
        do_start();
        term(8'h12, 2'd1);
        term(8'h12, 2'd1);
        idle_inputs();
        check("ar_pre", 32'(bus.result), 32'h0240);
        #1;
        reset_n = 1'b0;
        #1;
        check("ar_result",   32'(bus.result),   32'h0);
        check("ar_busy",     32'(bus.busy),     32'h0);
        check("ar_in_ready", 32'(bus.in_ready), 32'h0);
        check("ar_done",     32'(bus.done),     32'h0);
        check("ar_overflow", 32'(bus.overflow), 32'h0);
        #1;
        reset_n = 1'b1;
        tick();
        check("ar_idle_done", 32'(bus.done), 32'h0);
        check("ar_idle_busy", 32'(bus.busy), 32'h0);
        do_start();
        for (int i = 0; i < 4; i++) begin
            term(8'h12, 2'd1);
        end
        idle_inputs();
        check("ar_result2", 32'(bus.result), 32'h0480);
        check("ar_done2",   32'(bus.done),   32'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
